// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback mux: extracts sub-word loads and drives the register-file write port.
// Optional retired-instruction counter enabled by defining MEM_WB_RETIRE_CNT_EN.
module mem_wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic            in_regWrite,
  input  logic [4:0]      in_rd,
  input  logic [1:0]      in_wbSel,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_aluResult,
  input  logic [XLEN-1:0] in_memData,
  input  logic [XLEN-1:0] in_pc4,
  input  logic [XLEN-1:0] in_imm,
  output logic [4:0]      writeReg,
  output logic            regWrite,
  output logic [XLEN-1:0] writeData,
  output logic            wb_valid,
  output logic            misalign
`ifdef MEM_WB_RETIRE_CNT_EN
  ,
  output logic [63:0]     retire_count
`endif
);

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_IMM  = 2'b11;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic [4:0]      rd;
    logic [1:0]      wb_sel;
    logic [2:0]      funct3;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] mem;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] imm;
  } stage_t;

  stage_t stage_d, stage_q;

  // Flush beats stall so a bubble can enter even while the stage is held.
  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (!stall) begin
      stage_d.valid     = in_valid;
      stage_d.reg_write = in_regWrite;
      stage_d.rd        = in_rd;
      stage_d.wb_sel    = in_wbSel;
      stage_d.funct3    = in_funct3;
      stage_d.alu       = in_aluResult;
      stage_d.mem       = in_memData;
      stage_d.pc4       = in_pc4;
      stage_d.imm       = in_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  logic [1:0]      addr_lo;
  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [XLEN-1:0] load_data;
  logic            misalign_raw;

  assign addr_lo = stage_q.alu[1:0];

  always_comb begin
    load_byte = 8'h00;
    case (addr_lo)
      2'd0: load_byte = stage_q.mem[7:0];
      2'd1: load_byte = stage_q.mem[15:8];
      2'd2: load_byte = stage_q.mem[23:16];
      2'd3: load_byte = stage_q.mem[31:24];
      default: load_byte = 8'h00;
    endcase
    load_half = addr_lo[1] ? stage_q.mem[31:16] : stage_q.mem[15:0];
  end

  // Unused funct3 codes behave like LW, including the alignment check.
  always_comb begin
    load_data    = stage_q.mem;
    misalign_raw = (addr_lo != 2'b00);
    case (stage_q.funct3)
      3'b000: begin
        load_data    = {{(XLEN-8){load_byte[7]}}, load_byte};
        misalign_raw = 1'b0;
      end
      3'b100: begin
        load_data    = {{(XLEN-8){1'b0}}, load_byte};
        misalign_raw = 1'b0;
      end
      3'b001: begin
        load_data    = {{(XLEN-16){load_half[15]}}, load_half};
        misalign_raw = addr_lo[0];
      end
      3'b101: begin
        load_data    = {{(XLEN-16){1'b0}}, load_half};
        misalign_raw = addr_lo[0];
      end
      default: begin
        load_data    = stage_q.mem;
        misalign_raw = (addr_lo != 2'b00);
      end
    endcase
  end

  always_comb begin
    writeData = stage_q.alu;
    case (stage_q.wb_sel)
      WB_ALU:  writeData = stage_q.alu;
      WB_LOAD: writeData = load_data;
      WB_PC4:  writeData = stage_q.pc4;
      WB_IMM:  writeData = stage_q.imm;
      default: writeData = stage_q.alu;
    endcase
  end

  assign misalign = stage_q.valid & (stage_q.wb_sel == WB_LOAD) & misalign_raw;
  // x0 is filtered here as well so regWrite reflects a real architectural write.
  assign regWrite = stage_q.valid & stage_q.reg_write & (stage_q.rd != 5'd0) & ~misalign;
  assign writeReg = stage_q.rd;
  assign wb_valid = stage_q.valid;

`ifdef MEM_WB_RETIRE_CNT_EN
  logic [63:0] retire_count_d, retire_count_q;
  logic        retire_fire;

  // The held instruction retires when it leaves the stage, whether by capture or flush.
  assign retire_fire = stage_q.valid & (~stall | flush);

  always_comb begin
    retire_count_d = retire_count_q;
    if (retire_fire) retire_count_d = retire_count_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) retire_count_q <= '0;
    else     retire_count_q <= retire_count_d;
  end

  assign retire_count = retire_count_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: vector table for the writeback mux plus stall/flush/reset sequences.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        in_valid, in_regWrite;
  logic [4:0]  in_rd;
  logic [1:0]  in_wbSel;
  logic [2:0]  in_funct3;
  logic [31:0] in_aluResult, in_memData, in_pc4, in_imm;
  logic [4:0]  writeReg;
  logic        regWrite, wb_valid, misalign;
  logic [31:0] writeData;
`ifdef MEM_WB_RETIRE_CNT_EN
  logic [63:0] retire_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_regWrite(in_regWrite), .in_rd(in_rd),
    .in_wbSel(in_wbSel), .in_funct3(in_funct3), .in_aluResult(in_aluResult),
    .in_memData(in_memData), .in_pc4(in_pc4), .in_imm(in_imm),
    .writeReg(writeReg), .regWrite(regWrite), .writeData(writeData),
    .wb_valid(wb_valid), .misalign(misalign)
`ifdef MEM_WB_RETIRE_CNT_EN
    , .retire_count(retire_count)
`endif
  );

  typedef struct {
    logic        v, rw;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [31:0] alu, mem, pc4, imm;
    logic [4:0]  e_wr;
    logic        e_rw;
    logic [31:0] e_wd;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic rw, logic [4:0] rd, logic [1:0] sel, logic [2:0] f3,
                              logic [31:0] alu, logic [31:0] mem, logic [31:0] pc4, logic [31:0] imm,
                              logic e_rw, logic [31:0] e_wd, logic e_mis);
    vec_t t;
    t.v = v; t.rw = rw; t.rd = rd; t.sel = sel; t.f3 = f3;
    t.alu = alu; t.mem = mem; t.pc4 = pc4; t.imm = imm;
    t.e_wr = rd; t.e_rw = e_rw; t.e_wd = e_wd; t.e_mis = e_mis;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] pc4, input logic [31:0] imm);
    in_valid = v; in_regWrite = rw; in_rd = rd; in_wbSel = sel; in_funct3 = f3;
    in_aluResult = alu; in_memData = mem; in_pc4 = pc4; in_imm = imm;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [4:0] wr, input logic rw,
                         input logic [31:0] wd, input logic v, input logic mis);
    chk({tag, " writeReg"},  64'(writeReg),  64'(wr));
    chk({tag, " regWrite"},  64'(regWrite),  64'(rw));
    chk({tag, " writeData"}, 64'(writeData), 64'(wd));
    chk({tag, " wb_valid"},  64'(wb_valid),  64'(v));
    chk({tag, " misalign"},  64'(misalign),  64'(mis));
  endtask

  localparam logic [31:0] MD = 32'h80FF_7F01;

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 1'b1, 5'd9, 2'b10, 3'b000, 32'h1111_1111, MD, 32'h2222_2222, 32'h3333_3333);
    step; step;
    chk_out("reset", 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
`ifdef MEM_WB_RETIRE_CNT_EN
    chk("reset retire_count", retire_count, 64'd0);
`endif
    rst = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
    step;
    chk_out("idle", 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);

    //              v     rw    rd     sel    f3       alu            mem  pc4           imm            e_rw  e_wd           e_mis
    vecs.push_back(mk(1'b1, 1'b1, 5'd5, 2'b00, 3'b000, 32'h0000_1234, MD, 32'h0,        32'h0,        1'b1, 32'h0000_1234, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 5'd6, 2'b01, 3'b000, 32'h0000_0103, MD, 32'h0,        32'h0,        1'b1, 32'hFFFF_FF80, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 5'd6, 2'b01, 3'b100, 32'h0000_0103, MD, 32'h0,        32'h0,        1'b1, 32'h0000_0080, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 5'd6, 2'b01, 3'b001, 32'h0000_0102, MD, 32'h0,        32'h0,        1'b1, 32'hFFFF_80FF, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 5'd6, 2'b01, 3'b101, 32'h0000_0102, MD, 32'h0,        32'h0,        1'b1, 32'h0000_80FF, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 5'd8, 2'b01, 3'b010, 32'h0000_0102, MD, 32'h0,        32'h0,        1'b0, MD,            1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 5'd8, 2'b01, 3'b001, 32'h0000_0103, MD, 32'h0,        32'h0,        1'b0, 32'hFFFF_80FF, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 5'd7, 2'b01, 3'b000, 32'h0000_0103, MD, 32'h0,        32'h0,        1'b1, 32'hFFFF_FF80, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 5'd1, 2'b10, 3'b000, 32'h0000_0000, MD, 32'h0000_0044, 32'h0,       1'b1, 32'h0000_0044, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 5'd0, 2'b11, 3'b000, 32'h0000_0000, MD, 32'h0,        32'hABCD_E000, 1'b0, 32'hABCD_E000, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 5'd3, 2'b01, 3'b000, 32'h0000_0100, MD, 32'h0,        32'h0,        1'b1, 32'h0000_0001, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 5'd3, 2'b01, 3'b000, 32'h0000_0101, MD, 32'h0,        32'h0,        1'b1, 32'h0000_007F, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 5'd3, 2'b01, 3'b100, 32'h0000_0102, MD, 32'h0,        32'h0,        1'b1, 32'h0000_00FF, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 5'd3, 2'b01, 3'b001, 32'h0000_0100, MD, 32'h0,        32'h0,        1'b1, 32'h0000_7F01, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 5'd3, 2'b01, 3'b010, 32'h0000_0100, MD, 32'h0,        32'h0,        1'b1, MD,            1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 5'd4, 2'b01, 3'b011, 32'h0000_0100, MD, 32'h0,        32'h0,        1'b1, MD,            1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 5'd4, 2'b01, 3'b111, 32'h0000_0101, MD, 32'h0,        32'h0,        1'b0, MD,            1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 5'd4, 2'b01, 3'b010, 32'h0000_0102, MD, 32'h0,        32'h0,        1'b0, MD,            1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 5'd4, 2'b00, 3'b010, 32'h0000_0103, MD, 32'h0,        32'h0,        1'b1, 32'h0000_0103, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 5'd4, 2'b00, 3'b000, 32'h0000_00AA, MD, 32'h0,        32'h0,        1'b0, 32'h0000_00AA, 1'b0));

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].rw, vecs[i].rd, vecs[i].sel, vecs[i].f3,
            vecs[i].alu, vecs[i].mem, vecs[i].pc4, vecs[i].imm);
      step;
      chk_out($sformatf("vec%0d", i), vecs[i].e_wr, vecs[i].e_rw, vecs[i].e_wd, vecs[i].v, vecs[i].e_mis);
    end

    // Stall holds A for three cycles while B sits on the inputs.
    drive(1'b1, 1'b1, 5'd5, 2'b00, 3'b000, 32'h0000_1234, MD, 32'h0, 32'h0);
    step;
    drive(1'b1, 1'b1, 5'd9, 2'b10, 3'b000, 32'h0000_5678, MD, 32'h0000_0090, 32'h0);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step;
      chk_out($sformatf("stall%0d", k), 5'd5, 1'b1, 32'h0000_1234, 1'b1, 1'b0);
    end
    flush = 1'b1;
    step;
    chk_out("stall+flush", 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    stall = 1'b0; flush = 1'b0;
    step;
    chk_out("after flush B", 5'd9, 1'b1, 32'h0000_0090, 1'b1, 1'b0);
    flush = 1'b1;
    step;
    chk_out("flush only", 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    flush = 1'b0;

    // Reset during a stall discards the held instruction.
    step;
    stall = 1'b1; rst = 1'b1;
    step;
    chk_out("rst mid-stall", 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0; stall = 1'b0;

`ifdef MEM_WB_RETIRE_CNT_EN
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("rc after rst", retire_count, 64'd0);
    drive(1'b1, 1'b1, 5'd5, 2'b00, 3'b000, 32'h1, MD, 32'h0, 32'h0); step;
    drive(1'b1, 1'b1, 5'd6, 2'b00, 3'b000, 32'h2, MD, 32'h0, 32'h0); step;
    drive(1'b1, 1'b1, 5'd7, 2'b01, 3'b010, 32'h102, MD, 32'h0, 32'h0); step;
    drive(1'b1, 1'b1, 5'd0, 2'b11, 3'b000, 32'h0, MD, 32'h0, 32'hABCD_E000); step;
    drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0); step;
    chk("rc after bubble", retire_count, 64'd4);
    stall = 1'b1; step; step; stall = 1'b0;
    chk("rc after stall", retire_count, 64'd4);
    drive(1'b1, 1'b1, 5'd2, 2'b00, 3'b000, 32'h5, MD, 32'h0, 32'h0); step;
    stall = 1'b1; step;
    chk("rc held valid", retire_count, 64'd4);
    flush = 1'b1; step;
    chk("rc stall+flush", retire_count, 64'd5);
    stall = 1'b0; flush = 1'b0;
    drive(1'b1, 1'b1, 5'd2, 2'b00, 3'b000, 32'h5, MD, 32'h0, 32'h0); step;
    rst = 1'b1; step;
    chk("rc rst", retire_count, 64'd0);
    rst = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
